// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range sensor controller: periodic trigger, echo-width measurement in cm, presence flag.
// Define ULTRA_FILTER_EN to add 3-sample streak filtering with hysteresis on Led.
module ultrasonic_ranger #(
  parameter int CLK_HZ     = 50000000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int THRESH_CM  = 20,
  parameter int HYST_CM    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Echo,
  output logic       Trigger,
  output logic       Led,
  output logic [8:0] distance_cm,
  output logic       dist_valid,
  output logic       timeout
);
  localparam int US_DIV     = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
  localparam int TRIG_CYC   = int'((longint'(TRIG_US) * CLK_HZ) / 1000000);
  localparam int PERIOD_CYC = int'((longint'(PERIOD_MS) * CLK_HZ) / 1000);

  localparam logic [31:0] PRESC_LAST = 32'(US_DIV - 1);
  localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYC - 1);
  localparam logic [31:0] PER_LAST   = 32'(PERIOD_CYC - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_US - 1);
  localparam logic [8:0]  THR        = 9'(THRESH_CM);
  localparam logic [8:0]  NO_ECHO    = 9'd511;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRIG  = 3'd1;
  localparam logic [2:0] S_WRISE = 3'd2;
  localparam logic [2:0] S_MEAS  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] us_cnt_q, us_cnt_d;
  logic [5:0]  sub_q, sub_d;
  logic [8:0]  cm_q, cm_d;
  logic        stale_q, stale_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        trig_q, trig_d, led_q, led_d, dv_q, dv_d, to_q, to_d;
  logic [8:0]  dist_q, dist_d;
  logic        tick;
`ifdef ULTRA_FILTER_EN
  localparam logic [8:0] THR_HI = 9'(THRESH_CM + HYST_CM);
  logic [1:0] near_q, near_d, far_q, far_d;
`endif

  // Prescaler is parked while triggering so the first us tick lands cleanly after the pulse.
  assign tick = (state_q != S_TRIG) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    us_cnt_d = us_cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    stale_d  = stale_q;
    dist_d   = dist_q;
    led_d    = led_q;
    dv_d     = 1'b0;
    to_d     = 1'b0;
    sync1_d  = Echo;
    sync2_d  = sync1_q;
`ifdef ULTRA_FILTER_EN
    near_d   = near_q;
    far_d    = far_q;
`endif
    per_cnt_d = (per_cnt_q >= PER_LAST) ? per_cnt_q : per_cnt_q + 32'd1;
    presc_d   = (state_q == S_TRIG || tick) ? 32'd0 : presc_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (!armed_q || per_cnt_q >= PER_LAST) begin
          state_d   = S_TRIG;
          per_cnt_d = 32'd0;
          armed_d   = 1'b1;
        end
      end
      S_TRIG: begin
        if (per_cnt_q >= TRIG_LAST) begin
          state_d  = S_WRISE;
          us_cnt_d = 32'd0;
          stale_d  = sync2_q;
        end
      end
      S_WRISE: begin
        if (!sync2_q) stale_d = 1'b0;
        if (sync2_q && !stale_q) begin
          state_d  = S_MEAS;
          us_cnt_d = 32'd0;
          cm_d     = 9'd0;
          sub_d    = tick ? 6'd1 : 6'd0;
        end else if (tick && us_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          dist_d  = NO_ECHO;
          dv_d    = 1'b1;
          to_d    = 1'b1;
        end else if (tick) begin
          us_cnt_d = us_cnt_q + 32'd1;
        end
      end
      S_MEAS: begin
        if (!sync2_q) begin
          state_d = S_DONE;
          dist_d  = cm_q;
          dv_d    = 1'b1;
        end else if (tick && us_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          dist_d  = NO_ECHO;
          dv_d    = 1'b1;
          to_d    = 1'b1;
        end else if (tick) begin
          us_cnt_d = us_cnt_q + 32'd1;
          // 58 us of round-trip echo per cm
          if (sub_q == 6'd57) begin
            sub_d = 6'd0;
            if (cm_q < 9'd510) cm_d = cm_q + 9'd1;
          end else begin
            sub_d = sub_q + 6'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ULTRA_FILTER_EN
        if (!to_q && dist_q < THR) begin
          far_d  = 2'd0;
          near_d = (near_q == 2'd3) ? 2'd3 : near_q + 2'd1;
          if (near_d == 2'd3) led_d = 1'b1;
        end else if (to_q || dist_q >= THR_HI) begin
          near_d = 2'd0;
          far_d  = (far_q == 2'd3) ? 2'd3 : far_q + 2'd1;
          if (far_d == 2'd3) led_d = 1'b0;
        end else begin
          near_d = 2'd0;
          far_d  = 2'd0;
        end
`else
        led_d = !to_q && (dist_q < THR);
`endif
      end
      default: state_d = S_IDLE;
    endcase
    trig_d = (state_d == S_TRIG);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      per_cnt_q <= 32'd0;
      presc_q   <= 32'd0;
      us_cnt_q  <= 32'd0;
      sub_q     <= 6'd0;
      cm_q      <= 9'd0;
      stale_q   <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      trig_q    <= 1'b0;
      led_q     <= 1'b0;
      dv_q      <= 1'b0;
      to_q      <= 1'b0;
      dist_q    <= NO_ECHO;
`ifdef ULTRA_FILTER_EN
      near_q    <= 2'd0;
      far_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      per_cnt_q <= per_cnt_d;
      presc_q   <= presc_d;
      us_cnt_q  <= us_cnt_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      stale_q   <= stale_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      trig_q    <= trig_d;
      led_q     <= led_d;
      dv_q      <= dv_d;
      to_q      <= to_d;
      dist_q    <= dist_d;
`ifdef ULTRA_FILTER_EN
      near_q    <= near_d;
      far_q     <= far_d;
`endif
    end
  end

  assign Trigger     = trig_q;
  assign Led         = led_q;
  assign distance_cm = dist_q;
  assign dist_valid  = dv_q;
  assign timeout     = to_q;
endmodule
